// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, break hold-off
// Emits a one-cycle byte strobe per good frame and a one-cycle error strobe on a low stop bit.
module uart_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       CLK_100M,
  input  logic       SYS_RST,
  input  logic       UART_RXD,
  output logic       UART_RX_DVLD,
  output logic [7:0] UART_RX_DATA,
  output logic       UART_RX_FERR,
  output logic       UART_RX_BUSY
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       sh, sh_n;
  logic [7:0]       data_n;
  logic             dvld_n, ferr_n;
  logic             rxd_m, rxd_s;

  // Idle-high reset value keeps a reset from looking like a start edge.
  always_ff @(posedge CLK_100M) begin
    if (SYS_RST) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= UART_RXD;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge CLK_100M) begin
    if (SYS_RST) begin
      state        <= S_IDLE;
      cnt          <= '0;
      idx          <= '0;
      sh           <= '0;
      UART_RX_DATA <= 8'h00;
      UART_RX_DVLD <= 1'b0;
      UART_RX_FERR <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      sh           <= sh_n;
      UART_RX_DATA <= data_n;
      UART_RX_DVLD <= dvld_n;
      UART_RX_FERR <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    data_n  = UART_RX_DATA;
    dvld_n  = 1'b0;
    ferr_n  = 1'b0;

    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (!rxd_s) state_n = S_START;
      end

      // A start bit that is gone by mid-bit is treated as line noise.
      S_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rxd_s ? S_IDLE : S_DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          sh_n  = {rxd_s, sh[7:1]};
          if (idx == 3'd7) state_n = S_STOP;
          else             idx_n   = idx + 3'd1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      // Leaving at mid-stop-bit leaves half a bit of slack for the next start edge.
      S_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rxd_s) begin
            data_n  = sh;
            dvld_n  = 1'b1;
            state_n = S_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = S_BREAK;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      S_BREAK: begin
        cnt_n = '0;
        if (rxd_s) state_n = S_IDLE;
      end

      default: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  assign UART_RX_BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx at 1 Mbaud from 100 MHz (100 clocks per bit)
// Strobe latency from pin edge: 2 sync + HALF(50) + 9*100 + 1 = 953 cycles.
module tb_uart_rx;

  localparam int BIT   = 100;
  localparam int LAT   = 953;
  localparam int FRAME = 10 * BIT;

  logic       CLK_100M = 1'b0;
  logic       SYS_RST  = 1'b1;
  logic       UART_RXD = 1'b1;
  logic       UART_RX_DVLD;
  logic [7:0] UART_RX_DATA;
  logic       UART_RX_FERR;
  logic       UART_RX_BUSY;

  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  logic [7:0]  dv_data[$];
  int unsigned dv_cyc[$];
  int unsigned fe_cyc[$];

  uart_rx #(
    .CLK_FREQ(100_000_000),
    .BAUD    (1_000_000)
  ) dut (
    .CLK_100M    (CLK_100M),
    .SYS_RST     (SYS_RST),
    .UART_RXD    (UART_RXD),
    .UART_RX_DVLD(UART_RX_DVLD),
    .UART_RX_DATA(UART_RX_DATA),
    .UART_RX_FERR(UART_RX_FERR),
    .UART_RX_BUSY(UART_RX_BUSY)
  );

  always #5 CLK_100M = ~CLK_100M;
  always @(posedge CLK_100M) cyc <= cyc + 1;

  always @(negedge CLK_100M) begin
    if (UART_RX_DVLD) begin
      dv_data.push_back(UART_RX_DATA);
      dv_cyc.push_back(cyc);
    end
    if (UART_RX_FERR) fe_cyc.push_back(cyc);
    if (UART_RX_DVLD || UART_RX_FERR) begin
      vectors++;
      if (UART_RX_DVLD && UART_RX_FERR) begin
        miscompares++;
        $display("FAIL strobe_exclusive at cycle %0d: dvld=%b ferr=%b, required not both", cyc, UART_RX_DVLD, UART_RX_FERR);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK_100M);
      #1;
    end
  endtask

  task automatic send_bit(input logic v, input int n);
    UART_RXD = v;
    tick(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input int n, input logic stop);
    send_bit(1'b0, n);
    for (int i = 0; i < 8; i++) send_bit(b[i], n);
    send_bit(stop, n);
  endtask

  task automatic clear_log();
    dv_data.delete();
    dv_cyc.delete();
    fe_cyc.delete();
  endtask

  task automatic test_reset();
    SYS_RST  = 1'b1;
    UART_RXD = 1'b1;
    tick(3);
    vectors++; if (UART_RX_DVLD !== 1'b0)   begin miscompares++; $display("FAIL rst_dvld got %b want 0", UART_RX_DVLD); end
    vectors++; if (UART_RX_FERR !== 1'b0)   begin miscompares++; $display("FAIL rst_ferr got %b want 0", UART_RX_FERR); end
    vectors++; if (UART_RX_DATA !== 8'h00)  begin miscompares++; $display("FAIL rst_data got %h want 00", UART_RX_DATA); end
    vectors++; if (UART_RX_BUSY !== 1'b0)   begin miscompares++; $display("FAIL rst_busy got %b want 0", UART_RX_BUSY); end
    SYS_RST = 1'b0;
    clear_log();
    tick(10000);
    vectors++; if (dv_data.size() != 0)     begin miscompares++; $display("FAIL idle_dvld_count got %0d want 0", dv_data.size()); end
    vectors++; if (fe_cyc.size() != 0)      begin miscompares++; $display("FAIL idle_ferr_count got %0d want 0", fe_cyc.size()); end
    vectors++; if (UART_RX_DATA !== 8'h00)  begin miscompares++; $display("FAIL idle_data got %h want 00", UART_RX_DATA); end
    vectors++; if (UART_RX_BUSY !== 1'b0)   begin miscompares++; $display("FAIL idle_busy got %b want 0", UART_RX_BUSY); end
  endtask

  task automatic test_single_byte();
    int unsigned t0;
    clear_log();
    t0 = cyc;
    send_frame(8'h57, BIT, 1'b1);
    tick(50);
    vectors++; if (dv_data.size() != 1)     begin miscompares++; $display("FAIL single_count got %0d want 1", dv_data.size()); end
    if (dv_data.size() >= 1) begin
      vectors++; if (dv_data[0] !== 8'h57)  begin miscompares++; $display("FAIL single_data got %h want 57", dv_data[0]); end
      vectors++; if (dv_cyc[0] != t0 + LAT) begin miscompares++; $display("FAIL single_latency got %0d want %0d", dv_cyc[0] - t0, LAT); end
    end
    vectors++; if (fe_cyc.size() != 0)      begin miscompares++; $display("FAIL single_ferr got %0d want 0", fe_cyc.size()); end
    vectors++; if (UART_RX_DATA !== 8'h57)  begin miscompares++; $display("FAIL single_hold got %h want 57", UART_RX_DATA); end
    vectors++; if (UART_RX_BUSY !== 1'b0)   begin miscompares++; $display("FAIL single_busy got %b want 0", UART_RX_BUSY); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  msg[5];
    int unsigned t0;
    msg = '{8'h57, 8'h30, 8'h41, 8'h0D, 8'h0A};
    clear_log();
    t0 = cyc;
    for (int i = 0; i < 5; i++) send_frame(msg[i], BIT, 1'b1);
    tick(50);
    vectors++; if (dv_data.size() != 5)     begin miscompares++; $display("FAIL b2b_count got %0d want 5", dv_data.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < dv_data.size()) begin
        vectors++;
        if (dv_data[i] !== msg[i]) begin miscompares++; $display("FAIL b2b_data[%0d] got %h want %h", i, dv_data[i], msg[i]); end
        vectors++;
        if (dv_cyc[i] != t0 + LAT + i * FRAME) begin
          miscompares++;
          $display("FAIL b2b_time[%0d] got %0d want %0d", i, dv_cyc[i] - t0, LAT + i * FRAME);
        end
      end
    end
    vectors++; if (fe_cyc.size() != 0)      begin miscompares++; $display("FAIL b2b_ferr got %0d want 0", fe_cyc.size()); end
  endtask

  task automatic test_glitch();
    clear_log();
    send_bit(1'b0, 20);
    vectors++; if (UART_RX_BUSY !== 1'b1)   begin miscompares++; $display("FAIL glitch_busy_during got %b want 1", UART_RX_BUSY); end
    send_bit(1'b1, 300);
    vectors++; if (UART_RX_BUSY !== 1'b0)   begin miscompares++; $display("FAIL glitch_busy_after got %b want 0", UART_RX_BUSY); end
    vectors++; if (dv_data.size() + fe_cyc.size() != 0) begin
      miscompares++; $display("FAIL glitch_strobes got %0d want 0", dv_data.size() + fe_cyc.size());
    end
  endtask

  task automatic test_framing_error();
    int unsigned t0;
    clear_log();
    t0 = cyc;
    send_frame(8'hA5, BIT, 1'b0);
    send_bit(1'b0, 20000);
    vectors++; if (UART_RX_BUSY !== 1'b1)   begin miscompares++; $display("FAIL ferr_busy_break got %b want 1", UART_RX_BUSY); end
    vectors++; if (fe_cyc.size() != 1)      begin miscompares++; $display("FAIL ferr_count got %0d want 1", fe_cyc.size()); end
    if (fe_cyc.size() >= 1) begin
      vectors++; if (fe_cyc[0] != t0 + LAT) begin miscompares++; $display("FAIL ferr_latency got %0d want %0d", fe_cyc[0] - t0, LAT); end
    end
    vectors++; if (dv_data.size() != 0)     begin miscompares++; $display("FAIL ferr_dvld got %0d want 0", dv_data.size()); end
    vectors++; if (UART_RX_DATA !== 8'h0A)  begin miscompares++; $display("FAIL ferr_data_hold got %h want 0a", UART_RX_DATA); end
    send_bit(1'b1, 5);
    vectors++; if (UART_RX_BUSY !== 1'b0)   begin miscompares++; $display("FAIL ferr_busy_release got %b want 0", UART_RX_BUSY); end
    tick(500);
    vectors++; if (dv_data.size() + fe_cyc.size() != 1) begin
      miscompares++; $display("FAIL ferr_after_release got %0d strobes want 1", dv_data.size() + fe_cyc.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0]  b;
    int unsigned t0;
    b = 8'h3C;
    clear_log();
    send_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) send_bit(b[i], BIT);
    send_bit(b[4], BIT / 2);
    SYS_RST = 1'b1;
    tick(1);
    vectors++; if (UART_RX_DATA !== 8'h00)  begin miscompares++; $display("FAIL midrst_data got %h want 00", UART_RX_DATA); end
    vectors++; if (UART_RX_BUSY !== 1'b0)   begin miscompares++; $display("FAIL midrst_busy got %b want 0", UART_RX_BUSY); end
    vectors++; if (UART_RX_DVLD !== 1'b0)   begin miscompares++; $display("FAIL midrst_dvld got %b want 0", UART_RX_DVLD); end
    vectors++; if (UART_RX_FERR !== 1'b0)   begin miscompares++; $display("FAIL midrst_ferr got %b want 0", UART_RX_FERR); end
    SYS_RST = 1'b0;
    send_bit(1'b1, 2000);
    vectors++; if (dv_data.size() + fe_cyc.size() != 0) begin
      miscompares++; $display("FAIL midrst_aborted got %0d strobes want 0", dv_data.size() + fe_cyc.size());
    end
    t0 = cyc;
    send_frame(8'h46, BIT, 1'b1);
    tick(50);
    vectors++; if (dv_data.size() != 1)     begin miscompares++; $display("FAIL midrst_next_count got %0d want 1", dv_data.size()); end
    if (dv_data.size() >= 1) begin
      vectors++; if (dv_data[0] !== 8'h46)  begin miscompares++; $display("FAIL midrst_next_data got %h want 46", dv_data[0]); end
      vectors++; if (dv_cyc[0] != t0 + LAT) begin miscompares++; $display("FAIL midrst_next_latency got %0d want %0d", dv_cyc[0] - t0, LAT); end
    end
  endtask

  task automatic test_baud_skew();
    int bit_len[2];
    bit_len = '{98, 102};
    for (int r = 0; r < 2; r++) begin
      clear_log();
      send_frame(8'h55, bit_len[r], 1'b1);
      send_frame(8'hAA, bit_len[r], 1'b1);
      tick(200);
      vectors++; if (dv_data.size() != 2)   begin miscompares++; $display("FAIL skew%0d_count got %0d want 2", bit_len[r], dv_data.size()); end
      if (dv_data.size() >= 2) begin
        vectors++; if (dv_data[0] !== 8'h55) begin miscompares++; $display("FAIL skew%0d_byte0 got %h want 55", bit_len[r], dv_data[0]); end
        vectors++; if (dv_data[1] !== 8'hAA) begin miscompares++; $display("FAIL skew%0d_byte1 got %h want aa", bit_len[r], dv_data[1]); end
      end
      vectors++; if (fe_cyc.size() != 0)    begin miscompares++; $display("FAIL skew%0d_ferr got %0d want 0", bit_len[r], fe_cyc.size()); end
    end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_reset_mid_frame();
    test_baud_skew();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
